// File: rtl/ecc_sed_enc_sched.sv
// Round-robin front end for one shared even-parity SED encoder: grants one requester
// per cycle, feeds its word to the encoder and registers the returned codeword with its id.
module ecc_sed_enc_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 12,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      enc_data_valid,
    output logic [DATA_W-1:0]         enc_data,
    input  logic                      enc_valid,
    input  logic [DATA_W:0]           enc_codeword,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W:0]           out_codeword,
    output logic [ID_W-1:0]           out_id,
    output logic [15:0]               enc_count,
    output logic                      err_protocol,
    output logic                      dbg_out_full
);

    // Handshake: a word moves on a rising edge when valid and ready are both high
    // in that cycle; req_ready is the one-hot grant and also the accept.
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} out_state_e;

    out_state_e             r_state;
    out_state_e             w_state_next;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [DATA_W:0]        r_out_codeword;
    logic [ID_W-1:0]        r_out_id;
    logic [15:0]            r_enc_count;
    logic                   r_err_protocol;

    logic                   w_out_valid;
    logic                   w_can_accept;
    logic                   w_found;
    logic                   w_grant;
    logic [ID_W-1:0]        w_winner;
    logic [ID_W-1:0]        w_rr_next;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [DATA_W-1:0]      w_enc_data;

    assign w_can_accept = !w_out_valid || out_ready;

    // Search upward from r_rr_ptr with wrap; first valid requester wins.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(v_idx);
            end
        end
    end

    // Reset gates the grant so nothing is offered while rst is high.
    assign w_grant   = !rst && w_can_accept && w_found;
    assign w_rr_next = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_req_ready = '0;
        w_enc_data  = '0;
        if (w_grant) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_req_ready[i] = (int'(w_winner) == i);
            end
            w_enc_data = req_data[int'(w_winner)*DATA_W +: DATA_W];
        end
    end

    assign req_ready      = w_req_ready;
    assign enc_data       = w_enc_data;
    assign enc_data_valid = w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_grant) begin
            w_state_next = S_FULL;
        end else if (out_ready) begin
            w_state_next = S_EMPTY;
        end
    end

    always_comb begin
        w_out_valid  = (r_state == S_FULL);
        dbg_out_full = (r_state == S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_codeword <= '0;
            r_out_id       <= '0;
            r_rr_ptr       <= '0;
            r_enc_count    <= '0;
            r_err_protocol <= 1'b0;
        end else begin
            if (w_grant) begin
                r_out_codeword <= enc_codeword;
                r_out_id       <= w_winner;
                r_rr_ptr       <= w_rr_next;
                r_enc_count    <= r_enc_count + 16'd1;
            end
            // Encoder must answer in the same cycle it is driven; any disagreement sticks.
            if (w_grant != enc_valid) begin
                r_err_protocol <= 1'b1;
            end
        end
    end

    assign out_valid    = w_out_valid;
    assign out_codeword = r_out_codeword;
    assign out_id       = r_out_id;
    assign enc_count    = r_enc_count;
    assign err_protocol = r_err_protocol;

endmodule

// File: tb/tb_ecc_sed_enc_sched.sv
// Directed bench for ecc_sed_enc_sched; the bench plays the encoder as {^data, data}
// and can drop enc_valid to provoke the protocol error.
module tb_ecc_sed_enc_sched;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      enc_data_valid;
    logic [DATA_W-1:0]         enc_data;
    logic                      enc_valid;
    logic [DATA_W:0]           enc_codeword;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W:0]           out_codeword;
    logic [ID_W-1:0]           out_id;
    logic [15:0]               enc_count;
    logic                      err_protocol;
    logic                      dbg_out_full;
    logic                      bad_enc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W:0] exp_cw [NUM_REQ];

    always #5 clk = ~clk;

    ecc_sed_enc_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .enc_data_valid (enc_data_valid),
        .enc_data       (enc_data),
        .enc_valid      (enc_valid),
        .enc_codeword   (enc_codeword),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_codeword   (out_codeword),
        .out_id         (out_id),
        .enc_count      (enc_count),
        .err_protocol   (err_protocol),
        .dbg_out_full   (dbg_out_full)
    );

    assign enc_codeword = {^enc_data, enc_data};
    assign enc_valid    = enc_data_valid & ~bad_enc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_cw[0] = 13'h1111;
        exp_cw[1] = 13'h1222;
        exp_cw[2] = 13'h0333;
        exp_cw[3] = 13'h17FF;

        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0; bad_enc = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_cw", 32'(out_codeword), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_count", 32'(enc_count), 32'h0);
        check("rst_err", 32'(err_protocol), 32'h0);
        check("rst_dbg", 32'(dbg_out_full), 32'h0);

        // 1: async reset while FULL
        req_valid = 4'h1; req_data = {12'h000, 12'h000, 12'h000, 12'h00F};
        tick();
        check("t1_full", 32'(out_valid), 32'h1);
        check("t1_dbg_full", 32'(dbg_out_full), 32'h1);
        req_valid = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        check("t1_rst_out_valid", 32'(out_valid), 32'h0);
        check("t1_rst_req_ready", 32'(req_ready), 32'h0);
        check("t1_rst_enc_dv", 32'(enc_data_valid), 32'h0);
        check("t1_rst_count", 32'(enc_count), 32'h0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // 2: two words from requester 1
        req_data = {12'h000, 12'h000, 12'h0A5, 12'h000};
        req_valid = 4'b0010; out_ready = 1'b1;
        #1;
        check("t2_req_ready", 32'(req_ready), 32'h2);
        check("t2_enc_data", 32'(enc_data), 32'h0A5);
        check("t2_enc_dv", 32'(enc_data_valid), 32'h1);
        tick();
        check("t2_valid_a", 32'(out_valid), 32'h1);
        check("t2_cw_a", 32'(out_codeword), 32'h00A5);
        check("t2_id_a", 32'(out_id), 32'h1);
        req_data = {12'h000, 12'h000, 12'h001, 12'h000};
        tick();
        check("t2_cw_b", 32'(out_codeword), 32'h1001);
        check("t2_id_b", 32'(out_id), 32'h1);
        req_valid = '0;
        #1;
        check("t2_idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("t2_drain", 32'(out_valid), 32'h0);
        check("t2_count", 32'(enc_count), 32'h2);

        // 3: all requesters, round robin from pointer 0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_data = {12'h7FF, 12'h333, 12'h222, 12'h111};
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_valid", 32'(out_valid), 32'h1);
            check("t3_id", 32'(out_id), 32'(i % NUM_REQ));
            check("t3_cw", 32'(out_codeword), 32'(exp_cw[i % NUM_REQ]));
        end
        check("t3_count", 32'(enc_count), 32'h8);

        // 4: backpressure then release with no bubble
        out_ready = 1'b0;
        #1;
        check("t4_stall_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_cw", 32'(out_codeword), 32'h17FF);
            check("t4_hold_id", 32'(out_id), 32'h3);
            check("t4_hold_ready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_ready", 32'(req_ready), 32'h1);
        check("t4_release_dv", 32'(enc_data_valid), 32'h1);
        tick();
        check("t4_next_id", 32'(out_id), 32'h0);
        check("t4_next_cw", 32'(out_codeword), 32'h1111);
        check("t4_count", 32'(enc_count), 32'h9);

        // 5: grant 2, then 1001 -> 3 then 0
        req_valid = 4'b0100;
        #1;
        check("t5_ready_2", 32'(req_ready), 32'h4);
        tick();
        check("t5_id_2", 32'(out_id), 32'h2);
        req_valid = 4'b1001;
        #1;
        check("t5_ready_3", 32'(req_ready), 32'h8);
        tick();
        check("t5_id_3", 32'(out_id), 32'h3);
        #1;
        check("t5_ready_0", 32'(req_ready), 32'h1);
        tick();
        check("t5_id_0", 32'(out_id), 32'h0);
        req_valid = '0;

        // 6: encoder drops enc_valid during a grant; sticky until reset
        req_valid = 4'b0001; bad_enc = 1'b1;
        tick();
        check("t6_err", 32'(err_protocol), 32'h1);
        check("t6_capture_valid", 32'(out_valid), 32'h1);
        check("t6_capture_cw", 32'(out_codeword), 32'h1111);
        bad_enc = 1'b0; req_valid = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t6_err_held", 32'(err_protocol), 32'h1);
        end
        rst = 1'b1;
        #1;
        check("t6_err_cleared", 32'(err_protocol), 32'h0);
        tick();
        rst = 1'b0;

        // 6b: counter wrap
        req_valid = 4'hF; out_ready = 1'b1;
        repeat (65535) tick();
        check("t6_count_max", 32'(enc_count), 32'hFFFF);
        tick();
        check("t6_count_wrap", 32'(enc_count), 32'h0);
        check("t6_no_err", 32'(err_protocol), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ecc_sed_enc_sched.md
Name: ecc_sed_enc_sched

Overview:
- Round-robin scheduler that shares one combinational single-error-detect (even parity) encoder among NUM_REQ requesters.
- Each cycle it grants at most one requester and drives that requester's data word into the shared encoder.
- It captures the returned codeword into a registered output stage with valid/ready handshake, tagged with the requester id.
- It sits between the datapath clients and the encoder instance, one per protected bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 12, data word width; codeword width is DATA_W+1
ID_W, $clog2(NUM_REQ), derived localparam, width of out_id (not overridable)

Ports:
clk  input  1  clock, all flops on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*DATA_W  packed data; requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant/accept, combinational
enc_data_valid  output  1  drive to encoder data_valid
enc_data  output  DATA_W  drive to encoder data
enc_valid  input  1  encoder enc_valid
enc_codeword  input  DATA_W+1  encoder output {parity, data}
out_valid  output  1  registered codeword valid
out_ready  input  1  downstream accept
out_codeword  output  DATA_W+1  registered codeword
out_id  output  ID_W  requester index of out_codeword
enc_count  output  16  words encoded, wraps 0xFFFF->0
err_protocol  output  1  sticky encoder handshake error

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_codeword=0, out_id=0, enc_count=0, err_protocol=0, rr_ptr=0.
  - Any held entry is discarded; req_ready and enc_data_valid go low combinationally.
- Output stage has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1): out_codeword and out_id stay stable until out_ready=1.
- can_accept = !out_valid || out_ready. Draining and refilling in the same cycle is allowed, giving 1 word/cycle sustained throughput.
- Arbitration:
  - When can_accept && |req_valid: winner w is the first valid index at or after rr_ptr, searching upward with wrap mod NUM_REQ.
  - req_ready[w]=1, all other req_ready bits 0.
  - enc_data=req_data[w], enc_data_valid=1.
  - Otherwise req_ready=0, enc_data_valid=0, enc_data=0.
- Transfer on a clock edge with a grant:
  - out_codeword<=enc_codeword, out_id<=w, out_valid<=1.
  - rr_ptr<=(w+1) mod NUM_REQ.
  - enc_count<=enc_count+1.
- Latency is 1 cycle from the grant to out_valid.
- No grant and out_ready=1: out_valid<=0, rr_ptr unchanged.
- No grant while FULL and out_ready=0: everything holds.
- Protocol check: if enc_data_valid != enc_valid in any cycle, err_protocol<=1. It stays 1 until rst. The capture still happens on the grant.
- Fairness: with all requesters valid and out_ready=1, each is granted exactly once per NUM_REQ cycles. Worst-case wait is NUM_REQ-1 grants.
- The block does not modify data and does not compute parity itself. The bench golden model is out_codeword={^data, data}.

Test Plan:
1. Assert rst mid-cycle while FULL with req_valid=4'hF -> out_valid, req_ready, enc_data_valid all 0 immediately; enc_count=0.
2. Send requester 1 data 12'h0A5, then 12'h001, with out_ready=1 -> out_codeword=13'h00A5 with out_id=1, next cycle 13'h1001 with out_id=1; enc_count=2.
3. req_valid=4'hF held, out_ready=1, 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; enc_count=8; out_valid high continuously.
4. FULL with out_ready=0 for 5 cycles -> req_ready=0, out_codeword stable. Raise out_ready -> new grant in that same cycle, with no bubble.
5. After a grant to requester 2, set req_valid=4'b1001 -> requester 3 wins, then requester 0.
6. Force enc_valid=0 during a grant -> err_protocol=1 next cycle and held for 100 cycles until rst; enc_count at 0xFFFF plus one grant -> 0x0000.
